// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the MIPS-to-Avalon stall-injecting bridge.
package mips_avalon_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        FWD,
        RESP
    } state_t;

endpackage

// File: rtl/mips_lfsr16.sv
// 16-bit Fibonacci LFSR that steps once per cycle while advance is high.
module mips_lfsr16 import mips_avalon_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (advance) begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/mips_avalon_stall_bridge.sv
// Bridges a MIPS Avalon master to a RAM slave, injecting stall cycles per transfer.
// Define MIPS_AVALON_STALL_RANDOM_EN for LFSR-driven stall counts; otherwise every transfer stalls STALL_MAX cycles.
module mips_avalon_stall_bridge import mips_avalon_pkg::*; #(
    parameter int unsigned STALL_MAX = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m_address,
    input  logic [DATA_W-1:0] m_writedata,
    input  logic              m_read,
    input  logic              m_write,
    input  logic [BE_W-1:0]   m_byteenable,
    output logic              m_waitrequest,
    output logic [DATA_W-1:0] m_readdata,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    output logic              s_read,
    output logic              s_write,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              proto_err
);

    if (STALL_MAX > 15 || LFSR_SEED == 16'd0) begin : g_param_check
        $error("mips_avalon_stall_bridge: STALL_MAX must be 0..15 and LFSR_SEED nonzero");
    end

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  stall_n;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_writedata;
    logic [BE_W-1:0]   req_byteenable;
    logic              req_read;
    logic              req_write;
    logic              accept;
    logic              req_changed;

    assign accept = (state == IDLE) && (m_read || m_write);

`ifdef MIPS_AVALON_STALL_RANDOM_EN
    logic [15:0] lfsr;

    mips_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .value   (lfsr)
    );

    assign stall_n = CNT_W'({28'd0, lfsr[3:0]} % (STALL_MAX + 32'd1));
`else
    assign stall_n = CNT_W'(STALL_MAX);
`endif

    // The CPU must hold its whole request steady until the bridge releases it.
    assign req_changed = (m_address != req_address) || (m_writedata != req_writedata) ||
                         (m_byteenable != req_byteenable) ||
                         (m_read != req_read) || (m_write != req_write);

    assign s_address    = req_address;
    assign s_writedata  = req_writedata;
    assign s_byteenable = req_byteenable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the request latch is cleared too, so an aborted transfer leaves nothing to replay.
            state          <= IDLE;
            count          <= '0;
            req_address    <= '0;
            req_writedata  <= '0;
            req_byteenable <= '0;
            req_read       <= 1'b0;
            req_write      <= 1'b0;
            m_waitrequest  <= 1'b1;
            m_readdata     <= '0;
            s_read         <= 1'b0;
            s_write        <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every branch below see pre-edge state.
            if ((state == STALL || state == FWD) && req_changed) begin
                proto_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        req_address    <= m_address;
                        req_writedata  <= m_writedata;
                        req_byteenable <= m_byteenable;
                        req_read       <= m_read;
                        req_write      <= m_write;
                        count          <= stall_n;
                        if (m_read && m_write) begin
                            proto_err <= 1'b1;
                        end
                        if (stall_n == '0) begin
                            state   <= FWD;
                            s_read  <= m_read && !m_write;
                            s_write <= m_write;
                        end else begin
                            state <= STALL;
                        end
                    end
                end

                STALL: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state   <= FWD;
                        s_read  <= req_read && !req_write;
                        s_write <= req_write;
                    end
                end

                FWD: begin
                    if (!s_waitrequest) begin
                        if (s_read) begin
                            m_readdata <= s_readdata;
                        end
                        s_read        <= 1'b0;
                        s_write       <= 1'b0;
                        m_waitrequest <= 1'b0;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    m_waitrequest <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_avalon_stall_bridge.sv
// Self-checking bench: two bridges (STALL_MAX 3 and 0) against a word-level memory model.
module tb_mips_avalon_stall_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_address     [2];
    logic [31:0] m_writedata   [2];
    logic        m_read        [2];
    logic        m_write       [2];
    logic [3:0]  m_byteenable  [2];
    logic        m_waitrequest [2];
    logic [31:0] m_readdata    [2];
    logic [31:0] s_address     [2];
    logic [31:0] s_writedata   [2];
    logic        s_read        [2];
    logic        s_write       [2];
    logic [3:0]  s_byteenable  [2];
    logic        s_waitrequest [2];
    logic [31:0] s_readdata    [2];
    logic        proto_err     [2];

    always #5 clk = ~clk;

    mips_avalon_stall_bridge #(.STALL_MAX(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .m_address(m_address[0]), .m_writedata(m_writedata[0]), .m_read(m_read[0]),
        .m_write(m_write[0]), .m_byteenable(m_byteenable[0]), .m_waitrequest(m_waitrequest[0]),
        .m_readdata(m_readdata[0]), .s_address(s_address[0]), .s_writedata(s_writedata[0]),
        .s_read(s_read[0]), .s_write(s_write[0]), .s_byteenable(s_byteenable[0]),
        .s_waitrequest(s_waitrequest[0]), .s_readdata(s_readdata[0]), .proto_err(proto_err[0])
    );

    mips_avalon_stall_bridge #(.STALL_MAX(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .m_address(m_address[1]), .m_writedata(m_writedata[1]), .m_read(m_read[1]),
        .m_write(m_write[1]), .m_byteenable(m_byteenable[1]), .m_waitrequest(m_waitrequest[1]),
        .m_readdata(m_readdata[1]), .s_address(s_address[1]), .s_writedata(s_writedata[1]),
        .s_read(s_read[1]), .s_write(s_write[1]), .s_byteenable(s_byteenable[1]),
        .s_waitrequest(s_waitrequest[1]), .s_readdata(s_readdata[1]), .proto_err(proto_err[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int stall_max(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    function automatic logic [31:0] init_word(input int d, input int i);
        if (d == 0 && i == 0) return 32'h2402_0005;
        return (32'(i) * 32'h0101_0101) ^ (d == 0 ? 32'hA5A5_0000 : 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // RAM slave: holds waitrequest for the requested number of cycles, then completes.
    logic [31:0] ram [2][256];
    bit          ram_ready = 0;
    int          wait_req  [2];
    int          wait_left [2];
    bit          act_prev  [2];
    int          xfers     [2];
    int          fwd_cnt   [2];
    logic [31:0] log_addr  [2];
    logic [31:0] log_data  [2];
    logic [3:0]  log_be    [2];
    logic        log_wr    [2];

    always @(negedge clk) begin
        if (!ram_ready) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 256; i++) ram[d][i] = init_word(d, i);
                xfers[d] = 0; fwd_cnt[d] = 0; act_prev[d] = 0; wait_left[d] = 0;
            end
            ram_ready = 1;
        end
        for (int d = 0; d < 2; d++) begin
            if (s_read[d] || s_write[d]) begin
                if (!act_prev[d]) wait_left[d] = wait_req[d];
                fwd_cnt[d]++;
                if (wait_left[d] > 0) begin
                    s_waitrequest[d] = 1'b1;
                    wait_left[d]--;
                end else begin
                    s_waitrequest[d] = 1'b0;
                    s_readdata[d]    = ram[d][s_address[d][9:2]];
                    if (s_write[d])
                        ram[d][s_address[d][9:2]] = merge(ram[d][s_address[d][9:2]],
                                                          s_writedata[d], s_byteenable[d]);
                    log_addr[d] = s_address[d];
                    log_data[d] = s_writedata[d];
                    log_be[d]   = s_byteenable[d];
                    log_wr[d]   = s_write[d];
                    xfers[d]++;
                end
                act_prev[d] = 1;
            end else begin
                s_waitrequest[d] = 1'b1;
                act_prev[d]      = 0;
            end
        end
    end

    // Reference model: what memory should hold and what the CPU should see.
    logic [31:0] model_mem [2][256];
    logic [31:0] last_rd   [2];
    logic        exp_perr  [2];

    // Starts at a negedge. Returns at the next IDLE negedge, or at the RESP negedge when hold=1.
    task automatic xfer(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int waits,
                        input bit b2b, input bit hold, input bit tamper);
        int          n;
        int          x0;
        int          f0;
        bit          done;
        logic [31:0] exp_rd;
        wait_req[d]     = waits;
        x0              = xfers[d];
        f0              = fwd_cnt[d];
        m_address[d]    = addr;
        m_writedata[d]  = wdata;
        m_byteenable[d] = be;
        m_read[d]       = rd;
        m_write[d]      = wr;
        if (rd && wr) exp_perr[d] = 1'b1;
        n    = 0;
        done = 0;
        while (!done && n < 60) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 1 && tamper) begin
                m_address[d] = addr + 32'd4;
                exp_perr[d]  = 1'b1;
            end
            if (!m_waitrequest[d]) done = 1;
        end
        check("resp_seen", done, 1);
        if (b2b) n--;
`ifdef MIPS_AVALON_STALL_RANDOM_EN
        check("latency_range", (n >= 2 + waits) && (n <= 2 + waits + stall_max(d)), 1);
`else
        check("latency", n, 2 + waits + stall_max(d));
`endif
        check("fwd_cycles", fwd_cnt[d] - f0, waits + 1);
        check("ram_xfers", xfers[d] - x0, 1);
        check("ram_addr", log_addr[d], addr);
        check("ram_be", log_be[d], be);
        check("ram_op", log_wr[d], wr);
        check("s_idle_in_resp", s_read[d] | s_write[d], 0);
        if (wr) begin
            check("ram_wdata", log_data[d], wdata);
            model_mem[d][addr[9:2]] = merge(model_mem[d][addr[9:2]], wdata, be);
            check("readdata_kept", m_readdata[d], last_rd[d]);
        end else begin
            exp_rd = model_mem[d][addr[9:2]];
            check("readdata", m_readdata[d], exp_rd);
            last_rd[d] = exp_rd;
        end
        check("proto_err", proto_err[d], exp_perr[d]);
        if (!hold) begin
            m_read[d]  = 1'b0;
            m_write[d] = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_waitreq"}, m_waitrequest[d], 1);
            check({tag, "_s_rw"}, {s_read[d], s_write[d]}, 0);
            check({tag, "_s_addr"}, s_address[d], 0);
            check({tag, "_s_wdata_be"}, {s_writedata[d], s_byteenable[d]} == '0, 1);
            check({tag, "_readdata"}, m_readdata[d], 0);
            check({tag, "_proto_err"}, proto_err[d], 0);
            last_rd[d]  = '0;
            exp_perr[d] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pend;
        int          d;
        int          x0;
        int          n;
        bit          rd;
        bit          wr;
        bit          hold;
        logic [31:0] addr;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_address[k] = '0; m_writedata[k] = '0; m_byteenable[k] = '0;
            m_read[k] = 1'b0; m_write[k] = 1'b0; wait_req[k] = 0;
            for (int i = 0; i < 256; i++) model_mem[k][i] = init_word(k, i);
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        reset = 1'b0;
        @(negedge clk);

        // Boot-vector read with STALL_MAX=3, zero-wait RAM: five wait cycles.
        xfer(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'hF, 0, 0, 0, 0);
        // Single-cycle write with STALL_MAX=0, then read it back.
        xfer(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
        xfer(1, 1, 0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, 0, 0);
        // Slave holds waitrequest for two cycles.
        xfer(0, 1, 0, 32'h0000_0020, 32'h0, 4'hF, 2, 0, 0, 0);
        xfer(1, 1, 0, 32'h0000_0024, 32'h0, 4'hF, 2, 0, 0, 0);
        // Back-to-back: request held through RESP is taken only in the next IDLE.
        xfer(0, 1, 0, 32'h0000_0030, 32'h0, 4'hF, 0, 0, 1, 0);
        xfer(0, 0, 1, 32'h0000_0030, 32'h1234_5678, 4'h5, 1, 1, 0, 0);
        xfer(1, 0, 1, 32'h0000_0034, 32'hCAFE_F00D, 4'hA, 0, 0, 1, 0);
        xfer(1, 1, 0, 32'h0000_0034, 32'h0, 4'hF, 0, 1, 0, 0);

        pend = -1;
        for (int it = 0; it < 400; it++) begin
            d    = (pend >= 0) ? pend : int'($urandom_range(0, 1));
            rd   = $urandom_range(0, 1) == 1;
            wr   = !rd;
            hold = $urandom_range(0, 3) == 0;
            addr = $urandom & 32'hFFFF_FFFC;
            xfer(d, rd, wr, addr, $urandom, 4'($urandom_range(1, 15)),
                 int'($urandom_range(0, 3)), pend >= 0, hold, 0);
            pend = hold ? d : -1;
        end
        if (pend >= 0) begin
            m_read[pend] = 1'b0; m_write[pend] = 1'b0;
            @(posedge clk); @(negedge clk);
        end

        // Address changes mid-stall: flagged, RAM still sees the original address.
        xfer(0, 1, 0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 0, 1);
        xfer(0, 1, 0, 32'h0000_0200, 32'h0, 4'hF, 1, 0, 0, 0);
        // Read and write together: performed as a write and flagged.
        xfer(1, 1, 1, 32'h0000_0040, 32'h0BAD_0BAD, 4'hF, 0, 0, 0, 0);
        xfer(1, 1, 0, 32'h0000_0040, 32'h0, 4'hF, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_flag");
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a FWD cycle.
        wait_req[0] = 6;
        m_address[0] = 32'h0000_0044; m_writedata[0] = '0; m_byteenable[0] = 4'hF;
        m_read[0] = 1'b1; m_write[0] = 1'b0;
        n = 0;
        while (!s_read[0] && n < 20) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check("fwd_reached", s_read[0], 1);
        x0 = xfers[0];
        #2 reset = 1'b1;
        #1;
        check("rst_fwd_s_read", s_read[0], 0);
        check_reset_outputs("rst_fwd");
        m_read[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check("no_replay", {s_read[0], s_write[0], m_waitrequest[0]}, 3'b001);
        end
        check("aborted_not_done", xfers[0] - x0, 0);
        xfer(0, 1, 0, 32'h0000_0044, 32'h0, 4'hF, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_avalon_stall_bridge.md
MIPS_AVALON_STALL_BRIDGE -- requirements
Module: mips_avalon_stall_bridge

Interface
REQ-001 Parameter STALL_MAX, default 3, meaning maximum injected stall cycles per transfer (0..15).
REQ-002 Parameter LFSR_SEED, default 16'hACE1, meaning nonzero reset value of stall LFSR.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m_address/m_writedata  input  32 each  CPU-side request address / write data.
REQ-006 m_read, m_write  input  1 each  CPU-side read / write strobes.
REQ-007 m_byteenable  input  4  CPU-side byte lanes.
REQ-008 m_waitrequest  output  1  high = CPU must hold request.
REQ-009 m_readdata  output  32  read data, valid only in the RESP cycle.
REQ-010 s_address/s_writedata  output  32 each; s_read, s_write  output  1 each; s_byteenable  output  4  RAM-side request.
REQ-011 s_waitrequest  input  1; s_readdata  input  32  RAM-side response.
REQ-012 proto_err  output  1  sticky CPU protocol-violation flag.

Function
REQ-013 FSM states IDLE, STALL, FWD, RESP; state register, latched request and counters all flops.
REQ-014 m_waitrequest SHALL be 0 only in RESP, 1 in all other states.
REQ-015 IDLE: on m_read|m_write, latch address/writedata/byteenable/op, load stall count N, advance LFSR once; N>0 -> STALL, N=0 -> FWD.
REQ-016 STALL: s_read=s_write=0; decrement count each cycle; leave to FWD on the edge where count==1.
REQ-017 FWD: drive s_* from latched request; on s_waitrequest==0 capture s_readdata (reads only) and go RESP.
REQ-018 RESP: exactly one cycle, m_readdata = captured data (unchanged for writes), s_read=s_write=0, then IDLE.
REQ-019 Minimum latency: request seen in IDLE at cycle 0, N=0, zero-wait RAM -> RESP at cycle 2.
REQ-020 m_read and m_write both high in IDLE: treated as write, proto_err set.
REQ-021 Any change of m_address, m_read, m_write, m_byteenable or m_writedata while in STALL/FWD sets proto_err; latched request still used.
REQ-022 proto_err clears only on reset.
REQ-023 Back-to-back: request held high in RESP cycle is not accepted; new request accepted in the following IDLE cycle.

Reset
REQ-024 Asynchronous assert, in any state (incl. mid-FWD): state=IDLE, s_read=s_write=0, s_address/s_writedata/s_byteenable=0, m_readdata=0, m_waitrequest=1, proto_err=0, LFSR=LFSR_SEED, count=0.
REQ-025 Aborted transfer is not replayed after reset release.

Configuration
REQ-026 Macro MIPS_AVALON_STALL_RANDOM_EN defined: N = LFSR[3:0] mod (STALL_MAX+1).
REQ-027 Macro undefined: N = STALL_MAX for every transfer; LFSR logic absent.

Structure
REQ-028 Package mips_avalon_pkg holds state enum, LFSR tap constant (x^16+x^14+x^13+x^11+1), width constants.
REQ-029 One sub-module mips_lfsr16 (16-bit Fibonacci LFSR with advance enable), instantiated only under MIPS_AVALON_STALL_RANDOM_EN.

Verification
REQ-030 Macro undefined, STALL_MAX=3, read addr 0xBFC00000, RAM returns 0x24020005 zero-wait -> m_waitrequest high 5 cycles, RESP with m_readdata=0x24020005.
REQ-031 STALL_MAX=0, write 0xDEADBEEF to 0x00000010, byteenable 4'b1111 -> s_write high exactly 1 cycle with matching address/data, RESP at cycle 2.
REQ-032 RAM holds s_waitrequest high 2 cycles in FWD -> s_read held stable 3 cycles, RESP follows, proto_err=0.
REQ-033 Address changed 0x100 -> 0x104 during STALL -> proto_err=1, RAM sees 0x100, flag persists until reset.
REQ-034 Reset asserted mid-FWD -> s_read falls same timestep, m_waitrequest=1, state IDLE; next read completes normally.
REQ-035 Macro defined, 1000 random reads -> every N in 0..STALL_MAX, all readdata matches RAM model, no proto_err.
